// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and shared-ALU signals of alu_arbiter.
// lock0/lock1 are present only when ALU_ARB_LOCK_EN is defined.
`ifndef WORDSIZE
`define WORDSIZE 16
`endif
`ifndef ALUOPSIZE
`define ALUOPSIZE 2
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 2'd0
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 2'd1
`endif
`ifndef ALU_OP_AND
`define ALU_OP_AND 2'd2
`endif
`ifndef ALU_OP_OR
`define ALU_OP_OR 2'd3
`endif

interface alu_arbiter_if;
  logic                  req0_valid, req1_valid;
  logic                  req0_ready, req1_ready;
  logic [`ALUOPSIZE-1:0] req0_op, req1_op;
  logic [`WORDSIZE-1:0]  req0_a, req0_b, req1_a, req1_b;
`ifdef ALU_ARB_LOCK_EN
  logic                  lock0, lock1;
`endif
  logic                  resp_valid;
  logic                  resp_id;
  logic [`WORDSIZE-1:0]  resp_result;
  logic                  resp_zero;
  logic                  resp_ready;
  logic [`WORDSIZE-1:0]  alu_a, alu_b;
  logic [`ALUOPSIZE-1:0] alu_op;
  logic [`WORDSIZE-1:0]  alu_result;
  logic                  alu_zero;

  // Arbiter side.
  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
`ifdef ALU_ARB_LOCK_EN
    input  lock0, lock1,
`endif
    input  resp_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_zero,
    output alu_a, alu_b, alu_op
  );

  // Requesters plus the shared ALU.
  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
`ifdef ALU_ARB_LOCK_EN
    output lock0, lock1,
`endif
    output resp_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_zero,
    input  alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared ALU, one op in flight.
// Optional ALU_ARB_LOCK_EN lets the last-granted requester keep ownership via lockN.
`ifndef WORDSIZE
`define WORDSIZE 16
`endif
`ifndef ALUOPSIZE
`define ALUOPSIZE 2
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 2'd0
`endif

module alu_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [`WORDSIZE-1:0]  lat_a, lat_b, res_q;
  logic [`ALUOPSIZE-1:0] lat_op;
  logic                  lat_id, last_grant, res_id_q, res_zero_q;
  logic                  any_valid, grant_id, accept;

  always_comb begin : arbitrate
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant;
    else                                  grant_id = bus.req1_valid;
`ifdef ALU_ARB_LOCK_EN
    // A locked, still-valid owner overrides round-robin.
    if (!last_grant && bus.lock0 && bus.req0_valid)     grant_id = 1'b0;
    else if (last_grant && bus.lock1 && bus.req1_valid) grant_id = 1'b1;
`endif
  end

  assign accept = (state == IDLE) && any_valid;

  // NOTE: sequential state uses non-blocking (<=) so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin : next_state
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin : outputs
    bus.req0_ready = accept && !grant_id;
    bus.req1_ready = accept &&  grant_id;
    bus.resp_valid = (state == RESP);
  end

  // NOTE: these are plain registers, not a memory array, so all of them take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= `ALU_OP_ADD;
      lat_id     <= 1'b0;
      last_grant <= 1'b1;
      res_q      <= '0;
      res_zero_q <= 1'b0;
      res_id_q   <= 1'b0;
    end else begin
      if (accept) begin
        lat_a      <= grant_id ? bus.req1_a  : bus.req0_a;
        lat_b      <= grant_id ? bus.req1_b  : bus.req0_b;
        lat_op     <= grant_id ? bus.req1_op : bus.req0_op;
        lat_id     <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        res_q      <= bus.alu_result;
        res_zero_q <= bus.alu_zero;
        res_id_q   <= lat_id;
      end
    end
  end

  // The ALU only ever sees latched operands, so request ports may change freely after grant.
  assign bus.alu_a       = lat_a;
  assign bus.alu_b       = lat_b;
  assign bus.alu_op      = lat_op;
  assign bus.resp_result = res_q;
  assign bus.resp_zero   = res_zero_q;
  assign bus.resp_id     = res_id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter against a transaction-level model.
// Builds with or without ALU_ARB_LOCK_EN; lock scenarios run only when it is defined.
`ifndef WORDSIZE
`define WORDSIZE 16
`endif
`ifndef ALUOPSIZE
`define ALUOPSIZE 2
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 2'd0
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 2'd1
`endif
`ifndef ALU_OP_AND
`define ALU_OP_AND 2'd2
`endif
`ifndef ALU_OP_OR
`define ALU_OP_OR 2'd3
`endif

module tb_alu_arbiter;
  typedef logic [`WORDSIZE-1:0]  word_t;
  typedef logic [`ALUOPSIZE-1:0] op_t;

`ifdef ALU_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_last;   // model: index of the last accepted requester

  always #5 clk = ~clk;

  alu_arbiter_if bus ();
  alu_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic word_t alu_ref(input op_t op, input word_t a, input word_t b);
    case (op)
      `ALU_OP_ADD: return a + b;
      `ALU_OP_SUB: return a - b;
      `ALU_OP_AND: return a & b;
      default:     return a | b;
    endcase
  endfunction

  // Behavioural stand-in for the shared ALU.
  assign bus.alu_result = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_zero   = (bus.alu_result == '0);

  function automatic int model_pick(input logic v0, input logic v1, input logic l0, input logic l1);
    if (LOCK_EN && m_last == 0 && l0 && v0) return 0;
    if (LOCK_EN && m_last == 1 && l1 && v1) return 1;
    if (v0 && v1) return 1 - m_last;
    return v1 ? 1 : 0;
  endfunction

  task automatic drive(input logic v0, input op_t op0, input word_t a0, input word_t b0,
                       input logic v1, input op_t op1, input word_t a1, input word_t b1,
                       input logic l0, input logic l1);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
`ifdef ALU_ARB_LOCK_EN
    bus.lock0 = l0; bus.lock1 = l1;
`endif
  endtask

  task automatic idle_inputs();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    bus.resp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last = 1;
    @(negedge clk);
  endtask

  // One transaction: request seen in cycle T, EXEC in T+1, response from T+2, held 'hold' extra cycles.
  task automatic do_txn(input string tag,
                        input logic v0, input op_t op0, input word_t a0, input word_t b0,
                        input logic v1, input op_t op1, input word_t a1, input word_t b1,
                        input logic l0, input logic l1, input int hold);
    int    win;
    op_t   e_op;
    word_t e_a, e_b, e_res;
    logic  e_zero;
    drive(v0, op0, a0, b0, v1, op1, a1, b1, l0, l1);
    #1;
    win    = model_pick(v0, v1, l0, l1);
    e_op   = win ? op1 : op0;
    e_a    = win ? a1 : a0;
    e_b    = win ? b1 : b0;
    e_res  = alu_ref(e_op, e_a, e_b);
    e_zero = (e_res == '0);
    m_last = win;
    n_cmp++;
    if ({bus.req1_ready, bus.req0_ready} !== ((win == 1) ? 2'b10 : 2'b01)) begin
      n_err++;
      $display("FAIL %s grant: got ready1/0=%b%b want winner %0d", tag, bus.req1_ready, bus.req0_ready, win);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s exec: got resp_valid=%b ready1/0=%b%b want 0 00", tag,
               bus.resp_valid, bus.req1_ready, bus.req0_ready);
    end
    n_cmp++;
    if (bus.alu_op !== e_op || bus.alu_a !== e_a || bus.alu_b !== e_b) begin
      n_err++;
      $display("FAIL %s alu_drive: got op=%0d a=%h b=%h want op=%0d a=%h b=%h", tag,
               bus.alu_op, bus.alu_a, bus.alu_b, e_op, e_a, e_b);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== win[0] || bus.resp_result !== e_res || bus.resp_zero !== e_zero) begin
      n_err++;
      $display("FAIL %s resp: got v=%b id=%b res=%h z=%b want v=1 id=%0d res=%h z=%b", tag,
               bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_zero, win, e_res, e_zero);
    end
    for (int i = 0; i < hold; i++) begin
      drive(1'b1, op0, a0 ^ word_t'(i + 1), b0, 1'b1, op1, a1, b1 + word_t'(i), l0, l1);
      @(negedge clk);
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== win[0] || bus.resp_result !== e_res ||
          bus.resp_zero !== e_zero || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s stall%0d: got v=%b id=%b res=%h z=%b rdy=%b%b want v=1 id=%0d res=%h z=%b rdy=00",
                 tag, i, bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_zero,
                 bus.req1_ready, bus.req0_ready, win, e_res, e_zero);
      end
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.resp_result !== e_res || bus.resp_zero !== e_zero) begin
      n_err++;
      $display("FAIL %s release: got v=%b res=%h z=%b want v=0 res=%h z=%b", tag,
               bus.resp_valid, bus.resp_result, bus.resp_zero, e_res, e_zero);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.alu_op !== `ALU_OP_ADD) begin
      n_err++;
      $display("FAIL reset_async: got v=%b op=%0d want v=0 op=%0d", bus.resp_valid, bus.alu_op, `ALU_OP_ADD);
    end
    pulse_reset();
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
        bus.alu_op !== `ALU_OP_ADD || bus.alu_a !== '0 || bus.alu_b !== '0 ||
        bus.resp_id !== 1'b0 || bus.resp_result !== '0 || bus.resp_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b rdy=%b%b op=%0d a=%h b=%h id=%b res=%h z=%b want all zero, op=ADD",
               bus.resp_valid, bus.req1_ready, bus.req0_ready, bus.alu_op, bus.alu_a, bus.alu_b,
               bus.resp_id, bus.resp_result, bus.resp_zero);
    end
  endtask

  task automatic test_single();
    do_txn("add_5_3", 1'b1, `ALU_OP_ADD, 'd5, 'd3, 1'b0, `ALU_OP_OR, 'd9, 'd9, 1'b0, 1'b0, 0);
    n_cmp++;
    if (bus.resp_result !== word_t'(8) || bus.resp_zero !== 1'b0) begin
      n_err++;
      $display("FAIL add_5_3 value: got res=%h z=%b want res=8 z=0", bus.resp_result, bus.resp_zero);
    end
  endtask

  task automatic test_tie();
    pulse_reset();
    do_txn("tie_first",  1'b1, `ALU_OP_AND, 'h00F0, 'h000F, 1'b1, `ALU_OP_SUB, 'd7, 'd7, 1'b0, 1'b0, 0);
    do_txn("tie_second", 1'b1, `ALU_OP_AND, 'h00F0, 'h000F, 1'b1, `ALU_OP_SUB, 'd7, 'd7, 1'b0, 1'b0, 0);
  endtask

  task automatic test_stall();
    do_txn("stall5", 1'b1, `ALU_OP_OR, 'h1200, 'h0034, 1'b1, `ALU_OP_ADD, 'hFFFF, 'd1, 1'b0, 1'b0, 5);
  endtask

  task automatic test_reset_in_exec();
    drive(1'b1, `ALU_OP_ADD, 'd1, 'd2, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.alu_a !== '0 || bus.alu_op !== `ALU_OP_ADD || bus.resp_result !== '0) begin
      n_err++;
      $display("FAIL rst_exec: got v=%b a=%h op=%0d res=%h want v=0 a=0 op=ADD res=0",
               bus.resp_valid, bus.alu_a, bus.alu_op, bus.resp_result);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.resp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_exec_after%0d: got resp_valid=%b want 0", i, bus.resp_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic  v0, v1, l0, l1;
      op_t   op0, op1;
      word_t a0, b0, a1, b1;
      int    sel;
      sel = $urandom_range(2);
      v0  = (sel != 1);
      v1  = (sel != 0);
      op0 = op_t'($urandom_range(3));
      op1 = op_t'($urandom_range(3));
      a0  = word_t'($urandom);
      a1  = word_t'($urandom);
      b0  = ($urandom_range(3) == 0) ? a0 : word_t'($urandom);
      b1  = ($urandom_range(3) == 0) ? a1 : word_t'($urandom);
      l0  = LOCK_EN && ($urandom_range(1) == 1);
      l1  = LOCK_EN && ($urandom_range(1) == 1);
      do_txn($sformatf("rand%0d", i), v0, op0, a0, b0, v1, op1, a1, b1, l0, l1, $urandom_range(2));
    end
  endtask

  task automatic test_lock();
    pulse_reset();
    for (int i = 0; i < 3; i++)
      do_txn($sformatf("lock0_%0d", i), 1'b1, `ALU_OP_ADD, word_t'(i), 'd10, 1'b1, `ALU_OP_SUB, 'd50, word_t'(i),
             1'b1, 1'b0, 0);
    do_txn("lock0_drop", 1'b1, `ALU_OP_ADD, 'd4, 'd10, 1'b1, `ALU_OP_SUB, 'd50, 'd8, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_stall();
    test_reset_in_exec();
    test_random();
    if (LOCK_EN) test_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL be none; data width SHALL be `WORDSIZE and op width SHALL be `ALUOPSIZE, both from defines.h.
REQ-002 The block SHALL run on one clock; reset is asynchronous and active-low: clk input 1, rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  requester N's operation accepted this cycle.
REQ-006 reqN_op  input  `ALUOPSIZE  requester N opcode (`ALU_OP_ADD/SUB/AND/OR).
REQ-007 reqN_a, reqN_b  input  `WORDSIZE  requester N operands.
REQ-008 resp_valid  output  1  response held for the current owner.
REQ-009 resp_id  output  1  index of the requester the response belongs to.
REQ-010 resp_result  output  `WORDSIZE  captured ALU result.
REQ-011 resp_zero  output  1  captured ALU zero flag.
REQ-012 resp_ready  input  1  owner consumes the response.
REQ-013 alu_a, alu_b  output  `WORDSIZE  operands driven to the shared alu instance.
REQ-014 alu_op  output  `ALUOPSIZE  opcode driven to the shared alu.
REQ-015 alu_result  input  `WORDSIZE; alu_zero  input  1: shared alu outputs.
REQ-016 lockN  input  1  (only with ALU_ARB_LOCK_EN) requester N requests to keep ownership.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-018 In IDLE with any reqN_valid, the block SHALL assert exactly one reqN_ready combinationally, latch that requester's op/a/b and index into internal registers, and move to EXEC.
REQ-019 Arbitration SHALL be round-robin: single valid requester wins; if both are valid, the requester not granted last wins.
REQ-020 reqN_ready SHALL be 0 in EXEC and RESP and for the losing requester.
REQ-021 alu_a/alu_b/alu_op SHALL be driven from the latched registers at all times, never directly from request ports.
REQ-022 In EXEC the block SHALL capture alu_result and alu_zero into resp_result/resp_zero, set resp_id, and move to RESP.
REQ-023 In RESP resp_valid SHALL be 1 and resp_* SHALL be stable until resp_ready=1, then return to IDLE on that edge.
REQ-024 Latency: accept at edge T, resp_valid high from after edge T+2; peak throughput one operation per 3 cycles.
REQ-025 resp_valid SHALL be 0 in IDLE and EXEC; resp_result/resp_zero SHALL keep their last value when not valid.
REQ-026 The last-grant pointer SHALL update only on acceptance.
REQ-027 Opcodes SHALL be forwarded unchanged; opcode legality is the requester's responsibility.

Reset
REQ-028 On rst_n low, immediately and regardless of state: state=IDLE, resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, latched a/b=0, alu_op=`ALU_OP_ADD, last-grant=1 (req0 wins the first tie); an in-flight operation SHALL be discarded.

Configuration
REQ-029 Macro ALU_ARB_LOCK_EN SHALL add lock0/lock1.
REQ-030 With ALU_ARB_LOCK_EN: if the last-granted requester has lockN=1 and reqN_valid=1 in IDLE, it SHALL win regardless of round-robin; otherwise normal round-robin.
REQ-031 Without ALU_ARB_LOCK_EN: no lock ports, pure round-robin.

Verification
REQ-032 Reset: rst_n low then high, no requests -> resp_valid=0, req0_ready=req1_ready=0, alu_op=`ALU_OP_ADD.
REQ-033 req0 ADD 5,3 accepted at T -> resp_valid at T+2, resp_id=0, resp_result=8, resp_zero=0.
REQ-034 Both valid after reset, req0 AND 0xF0,0x0F, req1 SUB 7,7 -> req0 first (result 0, zero 1, id 0), then req1 (result 0, zero 1, id 1).
REQ-035 resp_ready low 5 cycles in RESP with both reqN_valid=1 -> resp_* stable, both readies 0.
REQ-036 rst_n pulsed low during EXEC -> resp_valid=0 at once, no response issued after release.
REQ-037 ALU_ARB_LOCK_EN, lock0=1, both valid continuously -> req0 granted 3 consecutive times; lock0 dropped -> next grant goes to req1.
